begi: RTL and testbench
=======================

BEGI -- requirements
Module: begi

Interface
REQ-001 Parameter Y_CYCLES, default 20: number of clock cycles each yellow phase lasts (legal values 1 to 255).
REQ-002 Parameter RR_CYCLES, default 20: number of clock cycles of the all-red clearance phase (legal values 1 to 255).
REQ-003 Parameter CTRY_MAX_GREEN, default 0: maximum country-green cycles before a forced exit; 0 means unlimited (legal values 0 to 255).
REQ-004 Port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-005 Port clr, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port X, input, 1 bit: country-road car sensor; 1 means a car is present.
REQ-007 Port hwy, output, 2 bits: highway lamp.
REQ-008 Port contry, output, 2 bits: country-road lamp.

Function
REQ-009 Lamp encoding SHALL be RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 SHALL never be driven.
REQ-010 The FSM SHALL have five states, encoded S0=3'b000 to S4=3'b100.
REQ-011 Outputs SHALL be Moore-decoded from the state register only:
- S0: hwy GREEN, contry RED
- S1: hwy YELLOW, contry RED
- S2: hwy RED, contry RED
- S3: hwy RED, contry GREEN
- S4: hwy RED, contry YELLOW
REQ-012 S0 transitions: X=1 at a rising edge -> S1 on that edge; X=0 -> stay in S0.
REQ-013 S1 SHALL last exactly Y_CYCLES cycles, then go to S2; X is ignored in S1.
REQ-014 S2 SHALL last exactly RR_CYCLES cycles, then go to S3; X is ignored in S2.
REQ-015 S3 SHALL last at least 1 cycle; at each edge in S3, X=0 -> S4, and X=1 -> stay in S3.
REQ-016 Forced exit from S3: if CTRY_MAX_GREEN>0, then after CTRY_MAX_GREEN cycles in S3 the FSM SHALL go to S4 even when X=1.
REQ-017 S4 SHALL last exactly Y_CYCLES cycles, then go to S0; X is ignored in S4.
REQ-018 The phase timer SHALL be 8 bits and SHALL reload on every state entry; it SHALL never wrap.
REQ-019 An illegal state encoding (3'b101 to 3'b111) SHALL go to S0 on the next edge.
REQ-020 X SHALL be used as a synchronous input; there is no internal synchronizer.

Reset
REQ-021 When clr=0 at a rising edge: state=S0, timer=0, hwy=GREEN, contry=RED.
REQ-022 Reset SHALL override all transitions, including assertion mid-phase in S1 to S4.
REQ-023 Reset SHALL take effect only on a clock edge; assertion between edges has no effect until the next edge.
REQ-024 After clr returns to 1, the FSM SHALL leave S0 only on a later edge with X=1.

Structure
REQ-025 A shared package begi_pkg SHALL hold the lamp color constants and the state enum.
REQ-026 There SHALL be one sub-module, phase_timer: an 8-bit loadable down-counter with a done flag.
REQ-027 begi SHALL instantiate phase_timer and hold the FSM plus output decode.
REQ-028 No latches; no delay constructs.

Verification
REQ-029 Reset: clr=0 for 2 cycles with X=1 -> hwy=2'b10, contry=2'b00 throughout.
REQ-030 Full cycle (Y_CYCLES=3, RR_CYCLES=2): X=1 from cycle 0, dropped after 4 cycles of S3 -> observed sequence:
- S1 for 3 cycles
- S2 for 2 cycles
- S3 for 4 cycles
- S4 for 3 cycles
- then S0 with hwy=GREEN
REQ-031 Idle: X=0 for 100 cycles -> remains in S0, hwy=GREEN, contry=RED.
REQ-032 Sensor glitch: X=1 for one edge in S0, then 0 -> full S1 and S2 phases, one S3 cycle, then S4 and back to S0.
REQ-033 Max green (CTRY_MAX_GREEN=5): X held at 1 -> S3 lasts exactly 5 cycles, then S4.
REQ-034 Mid-phase reset: clr=0 during the 2nd cycle of S2 -> next edge hwy=GREEN, contry=RED.

Source files
------------

// File: rtl/begi_pkg.sv
// BEGI highway/country-road traffic controller.
// Shared lamp colours, FSM state encoding and timer width.
package begi_pkg;

    typedef logic [1:0] lamp_t;

    localparam lamp_t LAMP_RED    = 2'b00;
    localparam lamp_t LAMP_YELLOW = 2'b01;
    localparam lamp_t LAMP_GREEN  = 2'b10;

    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_e;

endpackage

// File: rtl/begi_if.sv
// BEGI phase-timer link.
// The FSM is the master: it loads the timer and watches done.
interface begi_if;
    import begi_pkg::*;

    logic             load;
    logic [TMR_W-1:0] load_val;
    logic             done;

    modport master (output load, output load_val, input done);
    modport slave  (input load, input load_val, output done);

endinterface

// File: rtl/begi_phase_timer.sv
// BEGI phase timer.
// 8-bit loadable down-counter; holds at zero instead of wrapping.
module phase_timer
    import begi_pkg::*;
(
    input  logic   clk,
    input  logic   clr,
    begi_if.slave  tmr
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Load on request, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (tmr.load) begin
            cnt_d = tmr.load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmr.done = (cnt_q == '0);

endmodule

// File: rtl/begi.sv
// BEGI traffic controller top.
// Five-state Moore FSM sequencing highway and country-road lamps.
module begi
    import begi_pkg::*;
#(
    parameter int unsigned Y_CYCLES       = 20,
    parameter int unsigned RR_CYCLES      = 20,
    parameter int unsigned CTRY_MAX_GREEN = 0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       X,
    output logic [1:0] hwy,
    output logic [1:0] contry
);

    // A phase of N cycles is loaded with N-1 so done rises in its last cycle.
    localparam logic [TMR_W-1:0] Y_LOAD  = TMR_W'(Y_CYCLES - 1);
    localparam logic [TMR_W-1:0] RR_LOAD = TMR_W'(RR_CYCLES - 1);
    localparam bit               G_LIMIT = (CTRY_MAX_GREEN != 0);
    localparam logic [TMR_W-1:0] G_LOAD  =
        G_LIMIT ? TMR_W'(CTRY_MAX_GREEN - 1) : '0;

    state_e           state_q;
    state_e           state_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;

    begi_if tmr_if ();

    assign tmr_if.load     = tmr_load;
    assign tmr_if.load_val = tmr_val;

    phase_timer u_phase_timer (
        .clk (clk),
        .clr (clr),
        .tmr (tmr_if.slave)
    );

    // Next-state logic; undefined encodings fall back to S0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: if (X) state_d = S1;
            S1: if (tmr_if.done) state_d = S2;
            S2: if (tmr_if.done) state_d = S3;
            S3: if (!X || (G_LIMIT && tmr_if.done)) state_d = S4;
            S4: if (tmr_if.done) state_d = S0;
            default: state_d = S0;
        endcase
    end

    // Reload the timer whenever a new state is entered.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            S1:      tmr_val = Y_LOAD;
            S2:      tmr_val = RR_LOAD;
            S3:      tmr_val = G_LOAD;
            S4:      tmr_val = Y_LOAD;
            default: tmr_val = '0;
        endcase
    end

    // State register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore lamp decode from the state register only.
    always_comb begin
        hwy    = LAMP_RED;
        contry = LAMP_RED;
        case (state_q)
            S0: hwy    = LAMP_GREEN;
            S1: hwy    = LAMP_YELLOW;
            S2: hwy    = LAMP_RED;
            S3: contry = LAMP_GREEN;
            S4: contry = LAMP_YELLOW;
            default: hwy = LAMP_GREEN;
        endcase
    end

endmodule

// File: tb/tb_begi.sv
// BEGI testbench.
// Scoreboarded lamp checks on two configurations (unlimited and capped green).
module tb_begi;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    logic       clk = 1'b0;
    logic       clr_a, x_a, clr_b, x_b;
    logic [1:0] hwy_a, ctry_a, hwy_b, ctry_b;

    int         n_chk = 0;
    int         n_err = 0;
    int         sel   = 0;
    logic [3:0] sb_q[$];

    always #5 clk = ~clk;

    begi #(.Y_CYCLES(3), .RR_CYCLES(2), .CTRY_MAX_GREEN(0)) u_dut_a (
        .clk    (clk),
        .clr    (clr_a),
        .X      (x_a),
        .hwy    (hwy_a),
        .contry (ctry_a)
    );

    begi #(.Y_CYCLES(3), .RR_CYCLES(2), .CTRY_MAX_GREEN(5)) u_dut_b (
        .clk    (clk),
        .clr    (clr_b),
        .X      (x_b),
        .hwy    (hwy_b),
        .contry (ctry_b)
    );

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got hwy=%b contry=%b, expected hwy=%b contry=%b",
                     tag, got[3:2], got[1:0], exp[3:2], exp[1:0]);
        end
    endtask

    function automatic logic [3:0] lamps();
        return (sel == 0) ? {hwy_a, ctry_a} : {hwy_b, ctry_b};
    endfunction

    task automatic cyc(input string tag, input logic x, input logic c,
                       input logic [1:0] eh, input logic [1:0] ec);
        if (sel == 0) begin
            x_a = x; clr_a = c;
        end else begin
            x_b = x; clr_b = c;
        end
        sb_q.push_back({eh, ec});
        @(posedge clk);
        #1;
        check(tag, lamps(), sb_q.pop_front());
    endtask

    task automatic phase(input string tag, input int n, input logic x,
                         input logic c, input logic [1:0] eh,
                         input logic [1:0] ec);
        repeat (n) cyc(tag, x, c, eh, ec);
    endtask

    initial begin
        clr_a = 1'b0; x_a = 1'b1;
        clr_b = 1'b0; x_b = 1'b0;

        sel = 0;
        phase("reset",    2,   1'b1, 1'b0, GRN, RED);
        phase("idle",     100, 1'b0, 1'b1, GRN, RED);

        phase("full_s1",  3, 1'b1, 1'b1, YEL, RED);
        phase("full_s2",  2, 1'b1, 1'b1, RED, RED);
        phase("full_s3",  4, 1'b1, 1'b1, RED, GRN);
        phase("full_s4",  3, 1'b0, 1'b1, RED, YEL);
        phase("full_s0",  3, 1'b0, 1'b1, GRN, RED);

        cyc  ("glitch_go",   1'b1, 1'b1, YEL, RED);
        phase("glitch_s1", 2, 1'b0, 1'b1, YEL, RED);
        phase("glitch_s2", 2, 1'b0, 1'b1, RED, RED);
        phase("glitch_s3", 1, 1'b0, 1'b1, RED, GRN);
        phase("glitch_s4", 3, 1'b0, 1'b1, RED, YEL);
        phase("glitch_s0", 3, 1'b0, 1'b1, GRN, RED);

        cyc  ("mr_go",      1'b1, 1'b1, YEL, RED);
        phase("mr_s1",   2, 1'b1, 1'b1, YEL, RED);
        phase("mr_s2",   2, 1'b1, 1'b1, RED, RED);
        clr_a = 1'b0;
        #2;
        check("mr_between_edges", lamps(), {RED, RED});
        cyc  ("mr_rst",     1'b1, 1'b0, GRN, RED);
        phase("mr_hold", 3, 1'b0, 1'b1, GRN, RED);
        cyc  ("mr_leave",   1'b1, 1'b1, YEL, RED);
        phase("s1_rst",  2, 1'b1, 1'b0, GRN, RED);

        sel = 1;
        phase("mg_reset", 2, 1'b1, 1'b0, GRN, RED);
        phase("mg_s1",    3, 1'b1, 1'b1, YEL, RED);
        phase("mg_s2",    2, 1'b1, 1'b1, RED, RED);
        phase("mg_s3",    5, 1'b1, 1'b1, RED, GRN);
        phase("mg_s4",    3, 1'b1, 1'b1, RED, YEL);
        phase("mg_s0",    1, 1'b1, 1'b1, GRN, RED);
        phase("mg_again", 1, 1'b1, 1'b1, YEL, RED);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
